// File: rtl/pe_scan_ctrl_pkg.sv
// Shared widths, pipeline depth and state encoding for the PE scan sequencer.
package pe_scan_ctrl_pkg;

  // Default datapath widths for the controller and its interface.
  localparam int PKG_W_SIZE       = 8;
  localparam int PKG_W_CHANNEL    = 4;
  localparam int PKG_W_FRAME_SIZE = 12;

  // PE pipeline: 3 pre-calculation stages plus the PE datapath delay.
  localparam int PE_DELAY = 9;
  localparam int PKG_STG  = PE_DELAY + 3;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLOAD = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } scan_state_e;

endpackage

// File: rtl/pe_scan_ctrl_if.sv
// Config, filter-reload handshake and position stream between the top
// controller / IFM buffer / PE engine and the scan sequencer.
interface pe_scan_ctrl_if
  import pe_scan_ctrl_pkg::*;
#(
  parameter int W_SIZE       = PKG_W_SIZE,
  parameter int W_CHANNEL    = PKG_W_CHANNEL,
  parameter int W_FRAME_SIZE = PKG_W_FRAME_SIZE
);
  logic                    i_start;
  logic [W_SIZE-1:0]       i_width;
  logic [W_SIZE-1:0]       i_height;
  logic [W_CHANNEL-1:0]    i_num_tiles;
  logic                    i_ifm_ready;
  logic                    o_filter_load;
  logic                    i_filter_done;
  logic                    c_ctrl_data_run;
  logic                    c_ctrl_hsync_run;
  logic [W_SIZE-1:0]       c_row;
  logic [W_SIZE-1:0]       c_col;
  logic [W_CHANNEL-1:0]    c_chn;
  logic [W_FRAME_SIZE-1:0] c_data_count;
  logic                    c_is_first_row;
  logic                    c_is_last_row;
  logic                    c_is_first_col;
  logic                    c_is_last_col;
  logic                    c_end_frame;
  logic                    o_busy;

  // Sequencer side: consumes config/ready/done, drives the stream.
  modport master (
    input  i_start, i_width, i_height, i_num_tiles, i_ifm_ready, i_filter_done,
    output o_filter_load, c_ctrl_data_run, c_ctrl_hsync_run, c_row, c_col, c_chn,
           c_data_count, c_is_first_row, c_is_last_row, c_is_first_col,
           c_is_last_col, c_end_frame, o_busy
  );

  // Environment side: top controller, IFM buffer and PE engine.
  modport slave (
    output i_start, i_width, i_height, i_num_tiles, i_ifm_ready, i_filter_done,
    input  o_filter_load, c_ctrl_data_run, c_ctrl_hsync_run, c_row, c_col, c_chn,
           c_data_count, c_is_first_row, c_is_last_row, c_is_first_col,
           c_is_last_col, c_end_frame, o_busy
  );
endinterface

// File: rtl/pe_scan_ctrl_pos_counter.sv
// Nested row/col/chn position counter. col is innermost; a tile end wraps
// row and col to zero, and the channel tile is stepped separately so the
// sequencer can still see the finished tile's terminal count.
module pe_scan_ctrl_pos_counter #(
  parameter int W_SIZE    = 8,
  parameter int W_CHANNEL = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 advance,
  input  logic                 chn_inc,
  input  logic [W_SIZE-1:0]    width,
  input  logic [W_SIZE-1:0]    height,
  input  logic [W_CHANNEL-1:0] tiles,
  output logic [W_SIZE-1:0]    row,
  output logic [W_SIZE-1:0]    col,
  output logic [W_CHANNEL-1:0] chn,
  output logic                 col_tc,
  output logic                 row_tc,
  output logic                 chn_tc,
  output logic                 first_row,
  output logic                 last_row,
  output logic                 first_col,
  output logic                 last_col
);
  localparam logic [W_SIZE-1:0]    S_ONE = W_SIZE'(1);
  localparam logic [W_CHANNEL-1:0] C_ONE = W_CHANNEL'(1);

  logic [W_SIZE-1:0]    row_q, row_d;
  logic [W_SIZE-1:0]    col_q, col_d;
  logic [W_CHANNEL-1:0] chn_q, chn_d;

  // Terminal counts against the latched frame geometry.
  always_comb begin
    col_tc = (col_q == width - S_ONE);
    row_tc = (row_q == height - S_ONE);
    chn_tc = (chn_q == tiles - C_ONE);
  end

  // Location flags of the position about to be issued.
  always_comb begin
    first_row = (row_q == '0);
    last_row  = row_tc;
    first_col = (col_q == '0);
    last_col  = col_tc;
  end

  // Next position: col steps every beat, row at end of line.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    chn_d = chn_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
      chn_d = '0;
    end else begin
      if (advance) begin
        if (col_tc) begin
          col_d = '0;
          row_d = row_tc ? '0 : row_q + S_ONE;
        end else begin
          col_d = col_q + S_ONE;
        end
      end
      if (chn_inc) begin
        chn_d = chn_q + C_ONE;
      end
    end
  end

  // Position state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
      chn_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      chn_q <= chn_d;
    end
  end

  assign row = row_q;
  assign col = col_q;
  assign chn = chn_q;
endmodule

// File: rtl/pe_scan_ctrl.sv
// PE scan sequencer: per channel tile requests a filter reload, streams
// (row, col, chn) beats gated by IFM ready, then drains the PE pipeline and
// pulses end of frame. All outputs are registered.
module pe_scan_ctrl
  import pe_scan_ctrl_pkg::*;
#(
  parameter int W_SIZE       = PKG_W_SIZE,
  parameter int W_CHANNEL    = PKG_W_CHANNEL,
  parameter int W_FRAME_SIZE = PKG_W_FRAME_SIZE,
  parameter int STG          = PKG_STG
) (
  input  logic           clk,
  input  logic           rst,
  pe_scan_ctrl_if.master bus
);
  localparam int                      W_DRAIN    = $clog2(STG + 1);
  localparam logic [W_DRAIN-1:0]      DRAIN_LAST = W_DRAIN'(STG - 1);
  localparam logic [W_DRAIN-1:0]      DRAIN_ONE  = W_DRAIN'(1);
  localparam logic [W_FRAME_SIZE-1:0] CNT_ONE    = W_FRAME_SIZE'(1);

  scan_state_e             state_q, state_d;
  logic [W_SIZE-1:0]       width_q, width_d;
  logic [W_SIZE-1:0]       height_q, height_d;
  logic [W_CHANNEL-1:0]    tiles_q, tiles_d;
  logic [W_FRAME_SIZE-1:0] beat_cnt_q, beat_cnt_d;
  logic [W_DRAIN-1:0]      drain_cnt_q, drain_cnt_d;
  logic                    tile_end_q, tile_end_d;

  logic                    filter_load_q, filter_load_d;
  logic                    data_run_q, data_run_d;
  logic                    hsync_run_q, hsync_run_d;
  logic [W_SIZE-1:0]       row_q, row_d;
  logic [W_SIZE-1:0]       col_q, col_d;
  logic [W_CHANNEL-1:0]    chn_q, chn_d;
  logic [W_FRAME_SIZE-1:0] data_count_q, data_count_d;
  logic [3:0]              flags_q, flags_d;   // {first_row, last_row, first_col, last_col}
  logic                    end_frame_q, end_frame_d;
  logic                    busy_q, busy_d;

  logic                    cnt_clear, cnt_adv, cnt_chn_inc;
  logic [W_SIZE-1:0]       pos_row, pos_col;
  logic [W_CHANNEL-1:0]    pos_chn;
  logic                    col_tc, row_tc, chn_tc;
  logic                    pf_first_row, pf_last_row, pf_first_col, pf_last_col;
  logic                    cfg_ok;

  pe_scan_ctrl_pos_counter #(
    .W_SIZE    (W_SIZE),
    .W_CHANNEL (W_CHANNEL)
  ) u_pos (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear),
    .advance   (cnt_adv),
    .chn_inc   (cnt_chn_inc),
    .width     (width_q),
    .height    (height_q),
    .tiles     (tiles_q),
    .row       (pos_row),
    .col       (pos_col),
    .chn       (pos_chn),
    .col_tc    (col_tc),
    .row_tc    (row_tc),
    .chn_tc    (chn_tc),
    .first_row (pf_first_row),
    .last_row  (pf_last_row),
    .first_col (pf_first_col),
    .last_col  (pf_last_col)
  );

  // A start is only accepted for a non-degenerate frame.
  assign cfg_ok = (bus.i_width != '0) && (bus.i_height != '0) && (bus.i_num_tiles != '0);

  // Next state and next registered outputs. The tile end is handled one
  // cycle after the last beat is issued so the reload request lands in the
  // cycle after that beat is presented, and the drain starts from there.
  always_comb begin
    state_d       = state_q;
    width_d       = width_q;
    height_d      = height_q;
    tiles_d       = tiles_q;
    beat_cnt_d    = beat_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    tile_end_d    = tile_end_q;
    filter_load_d = 1'b0;
    data_run_d    = 1'b0;
    hsync_run_d   = 1'b0;
    row_d         = row_q;
    col_d         = col_q;
    chn_d         = chn_q;
    data_count_d  = data_count_q;
    flags_d       = 4'b0000;
    end_frame_d   = 1'b0;
    cnt_clear     = 1'b0;
    cnt_adv       = 1'b0;
    cnt_chn_inc   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_start && cfg_ok) begin
          width_d       = bus.i_width;
          height_d      = bus.i_height;
          tiles_d       = bus.i_num_tiles;
          beat_cnt_d    = '0;
          tile_end_d    = 1'b0;
          row_d         = '0;
          col_d         = '0;
          chn_d         = '0;
          data_count_d  = '0;
          cnt_clear     = 1'b1;
          filter_load_d = 1'b1;
          state_d       = ST_FLOAD;
        end
      end
      ST_FLOAD: begin
        if (bus.i_filter_done) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tile_end_q) begin
          tile_end_d = 1'b0;
          if (chn_tc) begin
            drain_cnt_d = '0;
            state_d     = ST_DRAIN;
          end else begin
            cnt_chn_inc   = 1'b1;
            filter_load_d = 1'b1;
            state_d       = ST_FLOAD;
          end
        end else if (bus.i_ifm_ready) begin
          data_run_d   = 1'b1;
          hsync_run_d  = pf_first_col;
          row_d        = pos_row;
          col_d        = pos_col;
          chn_d        = pos_chn;
          data_count_d = beat_cnt_q;
          flags_d      = {pf_first_row, pf_last_row, pf_first_col, pf_last_col};
          beat_cnt_d   = beat_cnt_q + CNT_ONE;
          cnt_adv      = 1'b1;
          tile_end_d   = col_tc && row_tc;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          end_frame_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // FSM state, latched config and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      width_q       <= '0;
      height_q      <= '0;
      tiles_q       <= '0;
      beat_cnt_q    <= '0;
      drain_cnt_q   <= '0;
      tile_end_q    <= 1'b0;
      filter_load_q <= 1'b0;
      data_run_q    <= 1'b0;
      hsync_run_q   <= 1'b0;
      row_q         <= '0;
      col_q         <= '0;
      chn_q         <= '0;
      data_count_q  <= '0;
      flags_q       <= 4'b0000;
      end_frame_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      width_q       <= width_d;
      height_q      <= height_d;
      tiles_q       <= tiles_d;
      beat_cnt_q    <= beat_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      tile_end_q    <= tile_end_d;
      filter_load_q <= filter_load_d;
      data_run_q    <= data_run_d;
      hsync_run_q   <= hsync_run_d;
      row_q         <= row_d;
      col_q         <= col_d;
      chn_q         <= chn_d;
      data_count_q  <= data_count_d;
      flags_q       <= flags_d;
      end_frame_q   <= end_frame_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.o_filter_load    = filter_load_q;
  assign bus.c_ctrl_data_run  = data_run_q;
  assign bus.c_ctrl_hsync_run = hsync_run_q;
  assign bus.c_row            = row_q;
  assign bus.c_col            = col_q;
  assign bus.c_chn            = chn_q;
  assign bus.c_data_count     = data_count_q;
  assign bus.c_is_first_row   = flags_q[3];
  assign bus.c_is_last_row    = flags_q[2];
  assign bus.c_is_first_col   = flags_q[1];
  assign bus.c_is_last_col    = flags_q[0];
  assign bus.c_end_frame      = end_frame_q;
  assign bus.o_busy           = busy_q;
endmodule
